// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_pkg
//  Description : Shared defaults and helper functions for the GPR/scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

    localparam int XLEN_D = 32;
    localparam int NREG_D = 32;

    // Ceiling log2, used to derive the register address width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of set bits in a default-sized pending vector.
    function automatic int popcount(input logic [NREG_D-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NREG_D; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_bypass_mux
//  Description : One read port: selects the stored word or a same-cycle write
//                (highest-index write port wins); register 0 always reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_bypass_mux
    import gpr_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [XLEN-1:0]     i_stored,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0]     o_data,
    output logic                o_hit
);

    logic            w_addr_nz;
    logic [XLEN-1:0] w_data;
    logic            w_hit;

    assign w_addr_nz = (i_rd_addr != '0);

    // Scan write ports in ascending order so the highest index overrides.
    always_comb begin
        w_hit  = 1'b0;
        w_data = i_stored;
        for (int j = 0; j < NWR; j++) begin
            if (w_addr_nz && i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr)) begin
                w_hit  = 1'b1;
                w_data = i_wr_data[j*XLEN +: XLEN];
            end
        end
        if (!w_addr_nz) begin
            w_data = '0;
        end
    end

    assign o_data = w_data;
    assign o_hit  = w_hit;

endmodule
`default_nettype wire

// File: rtl/gpr_sb.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_sb
//  Description : Multi-port register file with write-to-read bypass and a
//                per-register pending scoreboard with a registered count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_sb
    import gpr_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int NREG = NREG_D,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_ready_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic [AW:0]         pend_cnt_o,
    output logic [NREG-1:0]     pend_vec_o
);

    localparam int c_CNT_W = AW + 1;

    logic [XLEN-1:0]    r_regs [NREG];
    logic [NREG-1:0]    r_pend;
    logic [c_CNT_W-1:0] r_pend_cnt;

    logic [NREG-1:0]    w_pend_nxt;
    logic [c_CNT_W-1:0] w_n_set;
    logic [c_CNT_W-1:0] w_n_clr;

    // Register storage: later ports override earlier ones on the same address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                    r_regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Next pending state: writebacks clear, then a new issue sets (issue wins).
    always_comb begin
        w_pend_nxt = r_pend;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                w_pend_nxt[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en_i) begin
            w_pend_nxt[issue_rd_i] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Bits newly set and newly cleared this edge; several can clear at once.
    always_comb begin
        w_n_set = '0;
        w_n_clr = '0;
        for (int r = 0; r < NREG; r++) begin
            w_n_set = w_n_set + c_CNT_W'(w_pend_nxt[r] & ~r_pend[r]);
            w_n_clr = w_n_clr + c_CNT_W'(r_pend[r] & ~w_pend_nxt[r]);
        end
    end

    // Scoreboard bits and their running count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= r_pend_cnt + w_n_set - w_n_clr;
        end
    end

    assign pend_vec_o = r_pend;
    assign pend_cnt_o = r_pend_cnt;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd_port
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_hit;

            assign w_addr = rs_addr_i[k*AW +: AW];

            gpr_bypass_mux #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR)
            ) u_mux (
                .i_rd_addr (w_addr),
                .i_stored  (r_regs[w_addr]),
                .i_wr_en   (wr_en_i),
                .i_wr_addr (wr_addr_i),
                .i_wr_data (wr_data_i),
                .o_data    (w_data),
                .o_hit     (w_hit)
            );

            assign rs_data_o[k*XLEN +: XLEN] = w_data;
            // Same-cycle issue is deliberately not considered here.
            assign rs_ready_o[k] = (w_addr == '0) || !r_pend[w_addr] || w_hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpr_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_sb
//  Description : Directed self-checking bench for gpr_sb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_sb;

    logic        clk_i;
    logic        rst_i;
    logic [9:0]  rs_addr_i;
    logic [63:0] rs_data_o;
    logic [1:0]  rs_ready_o;
    logic [1:0]  wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        issue_en_i;
    logic [4:0]  issue_rd_i;
    logic [5:0]  pend_cnt_o;
    logic [31:0] pend_vec_o;

    int n_total;
    int n_bad;

    gpr_sb u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rs_addr_i  (rs_addr_i),
        .rs_data_o  (rs_data_o),
        .rs_ready_o (rs_ready_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .issue_en_i (issue_en_i),
        .issue_rd_i (issue_rd_i),
        .pend_cnt_o (pend_cnt_o),
        .pend_vec_o (pend_vec_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_i    = 2'b00;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        issue_en_i = 1'b0;
        issue_rd_i = '0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_i     = 1'b1;
        rs_addr_i = '0;
        idle_inputs();
        step();
        step();
        rst_i = 1'b0;
        #1;

        // Reset state across every address on both ports
        check_val("rst_cnt", 64'(pend_cnt_o), 64'd0);
        check_val("rst_vec", 64'(pend_vec_o), 64'd0);
        for (int a = 0; a < 32; a++) begin
            rs_addr_i = {5'(a), 5'(a)};
            #1;
            check_val("rst_data", rs_data_o, 64'd0);
            check_val("rst_ready", 64'(rs_ready_o), 64'd3);
        end

        // Bypass of a port-0 write to r5, then committed value
        rs_addr_i = {5'd5, 5'd5};
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd5};
        wr_data_i = {32'h0, 32'hDEADBEEF};
        #1;
        check_val("byp_r5", rs_data_o, {32'hDEADBEEF, 32'hDEADBEEF});
        step();
        idle_inputs();
        #1;
        check_val("commit_r5", rs_data_o, {32'hDEADBEEF, 32'hDEADBEEF});

        // Two ports writing r7: port 1 wins on bypass and commit
        rs_addr_i = {5'd5, 5'd7};
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd7, 5'd7};
        wr_data_i = {32'h2222, 32'h1111};
        #1;
        check_val("byp_r7", rs_data_o, {32'hDEADBEEF, 32'h2222});
        step();
        idle_inputs();
        #1;
        check_val("commit_r7", rs_data_o, {32'hDEADBEEF, 32'h2222});

        // Writes to r0 are neither bypassed nor stored
        rs_addr_i = {5'd0, 5'd0};
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd0};
        wr_data_i = {32'h0, 32'hFFFF_FFFF};
        #1;
        check_val("byp_r0", rs_data_o, 64'd0);
        step();
        idle_inputs();
        #1;
        check_val("commit_r0", rs_data_o, 64'd0);

        // Issue r3, observe stall, then writeback releases it
        issue_en_i = 1'b1;
        issue_rd_i = 5'd3;
        step();
        idle_inputs();
        rs_addr_i = {5'd0, 5'd3};
        #1;
        check_val("r3_ready", 64'(rs_ready_o), 64'b10);
        check_val("r3_cnt", 64'(pend_cnt_o), 64'd1);
        check_val("r3_vec", 64'(pend_vec_o), 64'h8);
        wr_en_i   = 2'b10;
        wr_addr_i = {5'd3, 5'd0};
        wr_data_i = {32'h42, 32'h0};
        #1;
        check_val("r3_wb_ready", 64'(rs_ready_o), 64'b11);
        check_val("r3_wb_data", rs_data_o, {32'h0, 32'h42});
        step();
        idle_inputs();
        #1;
        check_val("r3_clr_cnt", 64'(pend_cnt_o), 64'd0);
        check_val("r3_clr_vec", 64'(pend_vec_o), 64'd0);
        check_val("r3_clr_data", rs_data_o, {32'h0, 32'h42});

        // Same-cycle issue and write to r9: issue wins, data still commits
        issue_en_i = 1'b1;
        issue_rd_i = 5'd9;
        wr_en_i    = 2'b01;
        wr_addr_i  = {5'd0, 5'd9};
        wr_data_i  = {32'h0, 32'h99};
        step();
        idle_inputs();
        rs_addr_i = {5'd0, 5'd9};
        #1;
        check_val("r9_vec", 64'(pend_vec_o), 64'h200);
        check_val("r9_cnt", 64'(pend_cnt_o), 64'd1);
        check_val("r9_data", rs_data_o, {32'h0, 32'h99});
        check_val("r9_ready", 64'(rs_ready_o), 64'b10);

        // Issue to r0 is ignored
        issue_en_i = 1'b1;
        issue_rd_i = 5'd0;
        step();
        idle_inputs();
        #1;
        check_val("r0_issue_cnt", 64'(pend_cnt_o), 64'd1);
        check_val("r0_issue_vec", 64'(pend_vec_o), 64'h200);

        // Issue r1, r2, r4; same-cycle issue does not stall the reader
        rs_addr_i  = {5'd1, 5'd0};
        issue_en_i = 1'b1;
        issue_rd_i = 5'd1;
        #1;
        check_val("same_cyc_issue_ready", 64'(rs_ready_o), 64'b11);
        step();
        issue_rd_i = 5'd2;
        step();
        issue_rd_i = 5'd4;
        step();
        idle_inputs();
        #1;
        check_val("multi_cnt", 64'(pend_cnt_o), 64'd4);
        check_val("multi_vec", 64'(pend_vec_o), 64'h216);

        // Two writebacks in one edge clear two bits
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd2, 5'd1};
        wr_data_i = {32'hB2, 32'hA1};
        step();
        idle_inputs();
        #1;
        check_val("dual_clr_cnt", 64'(pend_cnt_o), 64'd2);
        check_val("dual_clr_vec", 64'(pend_vec_o), 64'h210);

        // Reset mid-operation discards activity presented with it
        rst_i      = 1'b1;
        issue_en_i = 1'b1;
        issue_rd_i = 5'd6;
        wr_en_i    = 2'b01;
        wr_addr_i  = {5'd0, 5'd6};
        wr_data_i  = {32'h0, 32'h1234};
        step();
        rst_i = 1'b0;
        idle_inputs();
        #1;
        check_val("post_rst_cnt", 64'(pend_cnt_o), 64'd0);
        check_val("post_rst_vec", 64'(pend_vec_o), 64'd0);
        for (int a = 0; a < 32; a++) begin
            rs_addr_i = {5'(a), 5'(a)};
            #1;
            check_val("post_rst_data", rs_data_o, 64'd0);
            check_val("post_rst_ready", 64'(rs_ready_o), 64'd3);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
